seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Receive-side counterpart of the digital-clock multiplexed display driver. The block samples the scanned seven-segment bus (segment lines, decimal point, per-digit enables) and recovers the displayed digits. It presents them as one parallel frame with a valid/ready handshake. It sits on the board-test and loopback path, where it checks the clock's display output without optical inspection.

## Interface
Parameters:
- NUM_DIGITS, 8, number of enable lines and digits per frame (1..8)
- SETTLE, 4, consecutive identical synchronized samples required before a digit is captured (≥1)

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset; asynchronous assert, active-low; all state cleared while low
- seg  in  7  segment lines, active-high; seg[0]=a … seg[6]=g
- dp  in  1  decimal point, active-high
- disp_en  in  NUM_DIGITS  digit enables, active-high, one-hot while a digit is driven
- frame_digits  out  5*NUM_DIGITS  digit i in bits [5i+4:5i]; codes 0x00–0x0F value, 0x10 blank, 0x1F invalid
- frame_dp  out  NUM_DIGITS  captured decimal points
- frame_valid  out  1  frame available
- frame_ready  in  1  consumer accepts frame
- frame_bad  out  1  held with frame: at least one digit is 0x1F
- err_onehot  out  1  one-cycle pulse: settled disp_en nonzero and not one-hot
- overrun  out  1  one-cycle pulse: completed frame dropped because frame_valid was high

## Operation
- Input conditioning: seg, dp and disp_en each pass through a 2-flop synchronizer. All logic below uses the synchronized values.
- Stability tracker, 3-state FSM:
  - WAIT: entered on reset or whenever any synchronized input differs from the previous cycle. The settle counter is cleared. Go to SETTLING the next cycle if inputs are unchanged.
  - SETTLING: the counter increments on each unchanged cycle. When it reaches SETTLE, evaluate the inputs and go to DONE.
  - DONE: hold until any input changes, then go to WAIT. Exactly one evaluation happens per stable period.
- Evaluation:
  - disp_en == 0: blanking interval, ignored.
  - disp_en not one-hot: pulse err_onehot; nothing is captured.
  - One-hot index i: store the decoded code and dp into working slot i, and set seen[i].
- Decode: exact match only.
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9.
  - 0x00→0x10 (blank).
  - Hex letters: see Configuration.
  - Any other pattern→0x1F.
- Frame commit: when seen becomes all-ones, clear seen.
  - If frame_valid is low, copy the working slots to the output registers and set frame_valid.
  - If frame_valid is high, pulse overrun and leave the outputs unchanged.
- Recapturing an already-seen index before the frame completes overwrites that slot. This is the latest-wins rule.
- Handshake: the frame transfers on a cycle where frame_valid && frame_ready. frame_valid clears the next cycle unless a commit occurs in that same cycle, in which case the new frame loads and frame_valid stays high. Output data is stable while frame_valid is high.
- Reset values: frame_digits 0, frame_dp 0, frame_valid 0, frame_bad 0, err_onehot 0, overrun 0; seen 0; FSM in WAIT.

## Timing
- Capture latency: 2 cycles for synchronization, plus SETTLE cycles of stability, plus 1 registered cycle. Example: with SETTLE=4, input stable from cycle 0 gives the slot written at cycle 7.
- frame_valid rises 1 cycle after the final slot write.
- err_onehot and overrun are registered one-cycle pulses.
- Reset asserted mid-frame discards partial and pending frames. No pulse is generated on reset release.

## Configuration
- SEG_SCAN_HEX_EN defined: additionally decode 0x77→0xA, 0x7C→0xB, 0x39→0xC, 0x5E→0xD, 0x79→0xE, 0x71→0xF.
- SEG_SCAN_HEX_EN undefined: those six patterns decode to 0x1F (invalid). Codes 0x0A–0x0F never appear.

## Structure
- Shared package holds:
  - Code constants CODE_BLANK=5'h10, CODE_INVALID=5'h1F.
  - The seven-segment pattern constants, shared with the display driver's encoder.
  - The FSM state enum {WAIT, SETTLING, DONE}.
- One sub-module, seg7_pattern_decode: combinational, 7-bit pattern → 5-bit code, honouring SEG_SCAN_HEX_EN.
- The top module holds the synchronizers, FSM, working slots and output buffer.

## Test plan
- Defaults, frame_ready=1; drive digits 0..7 with patterns for 1,2,5,9,0,3,7,8, 20 cycles each → frame_valid pulses once; frame_digits = {8,7,3,0,9,5,2,1} in 5-bit codes; frame_bad=0.
- Digit 2 driven with seg=0x7C:
  - Macro defined → code 0x0B, frame_bad=0.
  - Macro undefined → code 0x1F, frame_bad=1.
- Enable driven stable for only SETTLE+1 cycles (i.e. 1 cycle short of the capture threshold) → no capture, seen unchanged. disp_en=0x03 held 20 cycles → one err_onehot pulse and no capture.
- frame_ready=0, two full scans → first frame held unchanged, one overrun pulse. Raise frame_ready for 1 cycle → frame_valid drops the next cycle.
- Assert rst_n low after 5 of 8 digits captured, release, then complete a full scan → one frame containing only post-reset data; all outputs 0 during reset.
- seg glitch toggling every 2 cycles with SETTLE=4 → no captures and no err_onehot.

Source files
------------

// File: rtl/seg_scan_decoder_pkg.sv
// seg_scan_decoder_pkg: code constants, seven-segment patterns and tracker states shared by
// the scanned-display decoder (and the display driver's encoder).
package seg_scan_decoder_pkg;

  // Digit codes outside the 0x0-0xF value range
  localparam logic [4:0] CODE_BLANK   = 5'h10;
  localparam logic [4:0] CODE_INVALID = 5'h1F;

  // Segment patterns, seg[0]=a .. seg[6]=g, active-high
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;

  // Stability tracker states
  typedef enum logic [1:0] {
    StWait,
    StSettling,
    StDone
  } scan_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: exact-match seven-segment pattern to 5-bit digit code.
// Hex letters A-F are recognised only when SEG_SCAN_HEX_EN is defined; otherwise those
// patterns, like every other unknown pattern, decode to CODE_INVALID.
module seg7_pattern_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [4:0] code_o
);

  // Exact-match lookup; partial or extra segments are never rounded to a digit
  always_comb begin
    code_o = CODE_INVALID;
    case (pattern_i)
      SEG_0:     code_o = 5'h00;
      SEG_1:     code_o = 5'h01;
      SEG_2:     code_o = 5'h02;
      SEG_3:     code_o = 5'h03;
      SEG_4:     code_o = 5'h04;
      SEG_5:     code_o = 5'h05;
      SEG_6:     code_o = 5'h06;
      SEG_7:     code_o = 5'h07;
      SEG_8:     code_o = 5'h08;
      SEG_9:     code_o = 5'h09;
      SEG_BLANK: code_o = CODE_BLANK;
`ifdef SEG_SCAN_HEX_EN
      SEG_A:     code_o = 5'h0A;
      SEG_B:     code_o = 5'h0B;
      SEG_C:     code_o = 5'h0C;
      SEG_D:     code_o = 5'h0D;
      SEG_E:     code_o = 5'h0E;
      SEG_F:     code_o = 5'h0F;
`endif
      default:   code_o = CODE_INVALID;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed seven-segment bus, recovers each displayed digit
// once its enable has been stable long enough, and presents a full scan as one parallel
// frame with a valid/ready handshake. Hex-letter decode is enabled by SEG_SCAN_HEX_EN.
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SETTLE     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic                    dp,
  input  logic [NUM_DIGITS-1:0]   disp_en,
  output logic [5*NUM_DIGITS-1:0] frame_digits,
  output logic [NUM_DIGITS-1:0]   frame_dp,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    frame_bad,
  output logic                    err_onehot,
  output logic                    overrun
);

  localparam int unsigned InW  = 8 + NUM_DIGITS;
  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0]       CntLast = CntW'(SETTLE - 1);
  localparam logic [NUM_DIGITS-1:0] EnOne   = NUM_DIGITS'(1);

  logic [InW-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer across the whole bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {disp_en, dp, seg};
      sync2_q <= sync1_q;
    end
  end

  logic [6:0]            seg_s;
  logic                  dp_s;
  logic [NUM_DIGITS-1:0] en_s;
  assign {en_s, dp_s, seg_s} = sync2_q;

  // sync1_q is the synchronized bus one cycle ahead, so a mismatch flags a change of the
  // synchronized value without adding a third register stage to the capture latency.
  logic changing;
  assign changing = (sync1_q != sync2_q);

  scan_state_e     state_q;
  logic [CntW-1:0] cnt_q;
  logic            eval;

  // Final unchanged cycle of the settle window: evaluate the bus exactly once
  assign eval = (state_q == StSettling) && !changing && (cnt_q == CntLast);

  // Stability tracker: restart on any change, count unchanged cycles, then hold in done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StWait;
      cnt_q   <= '0;
    end else if (changing) begin
      state_q <= StWait;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StWait: begin
          state_q <= StSettling;
          cnt_q   <= '0;
        end
        StSettling: begin
          if (cnt_q == CntLast) state_q <= StDone;
          else                  cnt_q   <= cnt_q + 1'b1;
        end
        StDone:  state_q <= StDone;
        default: state_q <= StWait;
      endcase
    end
  end

  logic [4:0] code;

  seg7_pattern_decode u_decode (
    .pattern_i (seg_s),
    .code_o    (code)
  );

  logic en_any, en_onehot;
  assign en_any    = |en_s;
  assign en_onehot = en_any && ((en_s & (en_s - EnOne)) == '0);

  logic [NUM_DIGITS-1:0][4:0] work_code_q;
  logic [NUM_DIGITS-1:0]      work_dp_q;
  logic [NUM_DIGITS-1:0]      seen_q;
  logic                       capture, commit, work_bad;

  assign capture = eval && en_onehot;
  // Commit lands the cycle after the last slot write; no capture can coincide with it
  assign commit  = &seen_q;

  // Working slots: latest capture per enable wins until the frame completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_code_q <= '0;
      work_dp_q   <= '0;
      seen_q      <= '0;
    end else begin
      if (capture) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (en_s[i]) begin
            work_code_q[i] <= code;
            work_dp_q[i]   <= dp_s;
          end
        end
      end
      if (commit)       seen_q <= '0;
      else if (capture) seen_q <= seen_q | en_s;
    end
  end

  // Any invalid digit taints the whole frame
  always_comb begin
    work_bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (work_code_q[i] == CODE_INVALID) work_bad = 1'b1;
    end
  end

  // Output buffer and status pulses; a frame accepted this cycle frees room for a commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_digits <= '0;
      frame_dp     <= '0;
      frame_valid  <= 1'b0;
      frame_bad    <= 1'b0;
      err_onehot   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      err_onehot <= eval && en_any && !en_onehot;
      overrun    <= commit && frame_valid && !frame_ready;
      if (commit && (!frame_valid || frame_ready)) begin
        frame_digits <= work_code_q;
        frame_dp     <= work_dp_q;
        frame_bad    <= work_bad;
        frame_valid  <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed and randomized scans of the seven-segment bus, checked
// against a run-length reference model (a held bus value is evaluated once it has been
// sampled on SETTLE+2 consecutive clock edges).
module tb_seg_scan_decoder;

  localparam int unsigned N        = 8;
  localparam int unsigned SETTLE   = 4;
  localparam int unsigned MIN_HOLD = SETTLE + 2;

  localparam logic [6:0] PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [6:0]     seg = '0;
  logic           dp = 1'b0;
  logic [N-1:0]   disp_en = '0;
  logic           frame_ready = 1'b1;
  logic [5*N-1:0] frame_digits;
  logic [N-1:0]   frame_dp;
  logic           frame_valid, frame_bad, err_onehot, overrun;

  seg_scan_decoder #(
    .NUM_DIGITS (N),
    .SETTLE     (SETTLE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg          (seg),
    .dp           (dp),
    .disp_en      (disp_en),
    .frame_digits (frame_digits),
    .frame_dp     (frame_dp),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .frame_bad    (frame_bad),
    .err_onehot   (err_onehot),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5*N-1:0] digits;
    logic [N-1:0]   dps;
    logic           bad;
  } frame_t;

  // Reference model state
  frame_t         exp_q[$];
  logic [4:0]     m_code [N];
  logic           m_dp [N];
  logic [N-1:0]   m_seen;
  bit             m_valid;
  logic [N+7:0]   last_raw;
  int             run_len;
  bit             evald;
  int             exp_err, exp_ovr;

  // Observations
  int             got_err, got_ovr, frames_seen;
  logic [5*N-1:0] last_digits;
  logic           last_bad;

  int             n_checks, n_fail;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    int lim;
    lim = 10;
`ifdef SEG_SCAN_HEX_EN
    lim = 16;
`endif
    if (s == 7'h00) return 5'h10;
    for (int k = 0; k < lim; k++) if (PAT[k] == s) return 5'(k);
    return 5'h1F;
  endfunction

  task automatic model_reset();
    m_seen   = '0;
    m_valid  = 1'b0;
    exp_q.delete();
    last_raw = '0;
    run_len  = 0;
    evald    = 1'b0;
    for (int k = 0; k < N; k++) begin
      m_code[k] = '0;
      m_dp[k]   = 1'b0;
    end
  endtask

  task automatic model_eval(input logic [6:0] s, input logic d, input logic [N-1:0] en);
    frame_t f;
    if (en == '0) return;
    if ($countones(en) != 1) begin
      exp_err++;
      return;
    end
    for (int k = 0; k < N; k++) begin
      if (en[k]) begin
        m_code[k] = ref_decode(s);
        m_dp[k]   = d;
        m_seen[k] = 1'b1;
      end
    end
    if (&m_seen) begin
      m_seen = '0;
      if (m_valid) exp_ovr++;
      else begin
        f.bad = 1'b0;
        for (int k = 0; k < N; k++) begin
          f.digits[5*k +: 5] = m_code[k];
          f.dps[k]           = m_dp[k];
          if (m_code[k] == 5'h1F) f.bad = 1'b1;
        end
        exp_q.push_back(f);
        m_valid = 1'b1;
      end
    end
  endtask

  // Drive one bus value for a number of cycles (called just after a rising edge)
  task automatic drive(input logic [6:0] s, input logic d, input logic [N-1:0] en,
                       input int cycles);
    logic [N+7:0] raw;
    raw     = {en, d, s};
    seg     = s;
    dp      = d;
    disp_en = en;
    if (raw != last_raw) begin
      run_len = 0;
      evald   = 1'b0;
    end
    last_raw = raw;
    run_len += cycles;
    if (!evald && run_len >= int'(MIN_HOLD)) begin
      evald = 1'b1;
      model_eval(s, d, en);
    end
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [6:0] p [N], input logic [N-1:0] dps, input int hold);
    logic [N-1:0] one;
    one = 1;
    for (int k = 0; k < N; k++) drive(p[k], dps[k], one << k, hold);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_digits"}, 64'(frame_digits), 64'd0);
    check_val({tag, "_dp"},     64'(frame_dp),     64'd0);
    check_val({tag, "_valid"},  64'(frame_valid),  64'd0);
    check_val({tag, "_bad"},    64'(frame_bad),    64'd0);
    check_val({tag, "_err"},    64'(err_onehot),   64'd0);
    check_val({tag, "_ovr"},    64'(overrun),      64'd0);
  endtask

  // Output monitor: frames at handshake, stability while held, pulse counts
  initial begin
    bit             prev_hold, drop_chk;
    logic [5*N-1:0] held;
    frame_t         f;
    prev_hold = 1'b0;
    drop_chk  = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
        drop_chk  = 1'b0;
      end else begin
        if (err_onehot) got_err++;
        if (overrun)    got_ovr++;
        if (drop_chk) begin
          check_val("valid_drop", 64'(frame_valid), 64'd0);
          drop_chk = 1'b0;
        end
        if (prev_hold && frame_valid) check_val("hold_stable", 64'(frame_digits), 64'(held));
        if (frame_valid && frame_ready) begin
          frames_seen++;
          last_digits = frame_digits;
          last_bad    = frame_bad;
          check_val("frame_queued", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            f = exp_q.pop_front();
            check_val("frame_digits", 64'(frame_digits), 64'(f.digits));
            check_val("frame_dp",     64'(frame_dp),     64'(f.dps));
            check_val("frame_bad",    64'(frame_bad),    64'(f.bad));
          end
          m_valid   = 1'b0;
          drop_chk  = 1'b1;
          prev_hold = 1'b0;
        end else begin
          prev_hold = frame_valid;
          held      = frame_digits;
        end
      end
    end
  end

  initial begin
    int             vals [N];
    logic [6:0]     pats [N];
    logic [5*N-1:0] exp_a;
    logic [6:0]     s;
    logic [N-1:0]   en, one;
    int             c, kind, f0, e0, o0;

    one = 1;
    model_reset();
    rst_n       = 1'b0;
    frame_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(7'h00, 1'b0, '0, 5);

    // Basic scan: 1,2,5,9,0,3,7,8
    vals = '{1, 2, 5, 9, 0, 3, 7, 8};
    exp_a = '0;
    for (int k = 0; k < N; k++) begin
      pats[k]          = PAT[vals[k]];
      exp_a[5*k +: 5]  = 5'(vals[k]);
    end
    f0 = frames_seen;
    scan(pats, 8'hA5, 20);
    drive(7'h00, 1'b0, '0, 10);
    check_val("basic_count", 64'(frames_seen - f0), 64'd1);
    check_val("basic_digits", 64'(last_digits), 64'(exp_a));
    check_val("basic_bad", 64'(last_bad), 64'd0);

    // Hex letter b on digit 2
    pats[2] = 7'h7C;
    scan(pats, 8'h00, 20);
    drive(7'h00, 1'b0, '0, 10);
`ifdef SEG_SCAN_HEX_EN
    check_val("hex_digit2", 64'(last_digits[14:10]), 64'h0B);
    check_val("hex_bad", 64'(last_bad), 64'd0);
`else
    check_val("hex_digit2", 64'(last_digits[14:10]), 64'h1F);
    check_val("hex_bad", 64'(last_bad), 64'd1);
`endif

    // One cycle short of capture, then a non-one-hot enable held long
    e0 = got_err;
    f0 = frames_seen;
    drive(PAT[4], 1'b1, 8'h01, SETTLE + 1);
    drive(7'h00, 1'b0, '0, 20);
    drive(PAT[1], 1'b0, 8'h03, 20);
    drive(7'h00, 1'b0, '0, 10);
    check_val("onehot_err", 64'(got_err - e0), 64'd1);
    for (int k = 1; k < N; k++) drive(PAT[k], 1'b0, one << k, 20);
    check_val("short_no_capture", 64'(frames_seen - f0), 64'd0);
    drive(PAT[0], 1'b0, 8'h01, 20);
    check_val("short_complete", 64'(frames_seen - f0), 64'd1);

    // Two full scans with the consumer stalled
    frame_ready = 1'b0;
    o0 = got_ovr;
    for (int k = 0; k < N; k++) pats[k] = PAT[(k + 3) % 16];
    scan(pats, 8'h3C, 20);
    for (int k = 0; k < N; k++) pats[k] = PAT[(k + 9) % 10];
    scan(pats, 8'hC3, 20);
    drive(7'h00, 1'b0, '0, 10);
    check_val("stall_overrun", 64'(got_ovr - o0), 64'd1);
    check_val("stall_valid", 64'(frame_valid), 64'd1);
    check_val("stall_queue", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() > 0) check_val("stall_first_held", 64'(frame_digits), 64'(exp_q[0].digits));
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
    @(negedge clk);
    check_val("accept_drop", 64'(frame_valid), 64'd0);
    @(posedge clk); #1;
    frame_ready = 1'b1;

    // Reset after five of eight digits
    for (int k = 0; k < 5; k++) drive(PAT[15 - k], 1'b1, one << k, 20);
    seg = '0; dp = 1'b0; disp_en = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    f0 = frames_seen;
    for (int k = 0; k < N; k++) pats[k] = PAT[k];
    scan(pats, 8'h0F, 20);
    drive(7'h00, 1'b0, '0, 10);
    check_val("postrst_count", 64'(frames_seen - f0), 64'd1);

    // Segment glitch every 2 cycles on digit 0
    e0 = got_err;
    f0 = frames_seen;
    for (int r = 0; r < 10; r++) begin
      drive(PAT[1], 1'b0, 8'h01, 2);
      drive(PAT[2], 1'b0, 8'h01, 2);
    end
    drive(7'h00, 1'b0, '0, 10);
    for (int k = 1; k < N; k++) drive(PAT[k], 1'b0, one << k, 20);
    check_val("glitch_no_capture", 64'(frames_seen - f0), 64'd0);
    check_val("glitch_no_err", 64'(got_err - e0), 64'd0);
    drive(PAT[8], 1'b0, 8'h01, 20);
    check_val("glitch_complete", 64'(frames_seen - f0), 64'd1);

    // Randomized bus activity
    for (int r = 0; r < 120; r++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 7)       s = PAT[$urandom_range(0, 15)];
      else if (kind == 7) s = 7'h00;
      else                s = 7'($urandom);
      kind = int'($urandom_range(0, 9));
      if (kind < 8)       en = one << $urandom_range(0, N - 1);
      else if (kind == 8) en = '0;
      else                en = N'($urandom);
      if ($urandom_range(0, 3) == 0) c = int'($urandom_range(1, MIN_HOLD));
      else                           c = int'($urandom_range(MIN_HOLD, 20));
      drive(s, 1'($urandom), en, c);
    end
    drive(7'h00, 1'b0, '0, 30);

    check_val("total_err", 64'(got_err), 64'(exp_err));
    check_val("total_ovr", 64'(got_ovr), 64'(exp_ovr));
    check_val("pending_frames", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
